// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: prefetching instruction fetch unit; a FIFO of {instr, pc} fed by a 1-cycle RAM,
// flushed on redirect/reset with an epoch tag so stale responses never enter the queue.
module instr_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  start_pc,
  input  logic        redirect,
  input  logic [6:0]  redirect_pc,
  output logic        imem_rd_en,
  output logic [6:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [38:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [6:0]    fetch_pc, inflight_pc;
  logic          inflight, inflight_epoch, epoch, head, pop, push, issue;
  assign head = (count != '0) & ~rst;
  assign instr_valid = head;
  assign {instr, instr_pc} = head ? mem[rd_ptr] : '0;
  assign pop = head & instr_ready & ~redirect;
  assign push = ~rst & ~redirect & inflight & (inflight_epoch == epoch);
  // occupancy counts the in-flight read so the FIFO can never overflow when it lands
  assign occ = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = ~rst & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_rd_en = issue;
  assign imem_addr = fetch_pc;
  always_ff @(posedge clk)
    if (rst) begin
      fetch_pc <= start_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      epoch    <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      epoch    <= ~epoch;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 7'd1;
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc    <= fetch_pc;
      inflight_epoch <= epoch;
    end
    if (push) mem[wr_ptr] <= {imem_rdata, inflight_pc};
  end
  always_ff @(posedge clk)
    if (!rst) assert (!(push && count == CW'(DEPTH)));
endmodule
